// File: rtl/enemy_spawn_scheduler_pkg.sv
// Shared types and constants for the enemy spawn scheduler and related pools.
package enemy_pkg;

    localparam int NUM_SLOTS_DEFAULT  = 16;
    localparam int ID_W               = $clog2(NUM_SLOTS_DEFAULT);
    localparam int LANE_WIDTH_DEFAULT = 40;
    localparam int MAX_TYPE           = 15;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SEARCH = 2'd1,
        OFFER  = 2'd2
    } spawn_state_t;

    typedef logic [ID_W-1:0] enemy_id_t;

    // Population count of up to 32 slot flags.
    function automatic logic [5:0] pop_count32(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/enemy_spawn_scheduler_if.sv
// Spawn request channel between the scheduler and the enemy generator.
interface enemy_spawn_scheduler_if;
    logic        spawnValid;
    logic        spawnReady;
    logic [4:0]  spawnId;
    logic [3:0]  spawnType;
    logic [10:0] spawnLocation;

    modport master (
        output spawnValid,
        output spawnId,
        output spawnType,
        output spawnLocation,
        input  spawnReady
    );

    modport slave (
        input  spawnValid,
        input  spawnId,
        input  spawnType,
        input  spawnLocation,
        output spawnReady
    );
endinterface

// File: rtl/enemy_spawn_scheduler_free_slot_finder.sv
// Round-robin free slot search: lowest free slot at or above rr_ptr, wrapping.
module free_slot_finder #(
    parameter int N    = 16,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    alive_mask,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            found,
    output logic [ID_W-1:0] slot_id
);
    localparam int W1 = ID_W + 1;

    logic [2*N-1:0] free_x2;
    logic [N-1:0]   free_rot;
    logic [W1-1:0]  offset;
    logic [W1-1:0]  sum;

    // Doubling the free map makes the rotation by rr_ptr a plain shift.
    assign free_x2  = {~alive_mask, ~alive_mask};
    assign free_rot = N'(free_x2 >> rr_ptr);

    // Priority encode the rotated map; lowest offset from rr_ptr wins.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (free_rot[i]) begin
                found  = 1'b1;
                offset = W1'(i);
            end
        end
    end

    assign sum     = {1'b0, rr_ptr} + offset;
    assign slot_id = (sum >= W1'(N)) ? ID_W'(sum - W1'(N)) : sum[ID_W-1:0];

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// Enemy spawn scheduler: frame-paced slot allocation, spawn handshake, alive map.
module enemy_spawn_scheduler
    import enemy_pkg::*;
#(
    parameter int NUM_SLOTS    = NUM_SLOTS_DEFAULT,
    parameter int SPAWN_PERIOD = 60,
    parameter int MAX_ALIVE    = 8,
    parameter int LANE_WIDTH   = LANE_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      enable,
    input  logic [3:0]                randomType,
    input  logic [3:0]                randomLocation,
    input  logic                      enemyKilled,
    input  logic [4:0]                killedId,
    enemy_spawn_scheduler_if.master   spawn_if,
    output logic [NUM_SLOTS-1:0]      aliveMask,
    output logic [5:0]                aliveCount,
    output logic                      poolFull
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    spawn_state_t          state_q, state_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic [SLOT_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [SLOT_W-1:0]     spawn_id_q, spawn_id_d;
    logic [3:0]            spawn_type_q, spawn_type_d;
    logic [10:0]           spawn_loc_q, spawn_loc_d;
    logic [NUM_SLOTS-1:0]  alive_mask_q, alive_mask_d;
    logic [5:0]            alive_count_q, alive_count_d;
    logic                  pool_full_q, pool_full_d;
    logic                  accept;
    logic                  found;
    logic [SLOT_W-1:0]     found_id;

    free_slot_finder #(
        .N    (NUM_SLOTS),
        .ID_W (SLOT_W)
    ) u_finder (
        .alive_mask (alive_mask_q),
        .rr_ptr     (rr_ptr_q),
        .found      (found),
        .slot_id    (found_id)
    );

    // Next state: frame pacing, slot allocation and request acceptance.
    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        spawn_id_d   = spawn_id_q;
        spawn_type_d = spawn_type_q;
        spawn_loc_d  = spawn_loc_q;
        accept       = 1'b0;
        case (state_q)
            WAIT: begin
                if (startOfFrame && enable) begin
                    if (frame_cnt_q == 8'(SPAWN_PERIOD - 1)) begin
                        frame_cnt_d = '0;
                        state_d     = SEARCH;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            SEARCH: begin
                frame_cnt_d = '0;
                if (!enable) begin
                    state_d = WAIT;
                end else if (found && !pool_full_q) begin
                    spawn_id_d   = found_id;
                    spawn_type_d = randomType;
                    spawn_loc_d  = 11'(randomLocation) * 11'(LANE_WIDTH);
                    state_d      = OFFER;
                end
            end
            OFFER: begin
                // The request stays up even if enable drops; only the handshake ends it.
                if (spawn_if.spawnReady) begin
                    accept   = 1'b1;
                    rr_ptr_d = (spawn_id_q == SLOT_W'(NUM_SLOTS - 1)) ? '0
                                                                      : spawn_id_q + SLOT_W'(1);
                    state_d  = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // Alive map update; count and full flag derive from the next map so all three line up.
    always_comb begin
        alive_mask_d = alive_mask_q;
        if (accept) begin
            alive_mask_d[spawn_id_q] = 1'b1;
        end
        if (enemyKilled && (int'(killedId) < NUM_SLOTS)) begin
            alive_mask_d[killedId[SLOT_W-1:0]] = 1'b0;
        end
        alive_count_d = pop_count32(32'(alive_mask_d));
        pool_full_d   = (alive_count_d >= 6'(MAX_ALIVE)) || (&alive_mask_d);
    end

    // State and datapath registers; reset drops any pending request at once.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= WAIT;
            frame_cnt_q   <= '0;
            rr_ptr_q      <= '0;
            spawn_id_q    <= '0;
            spawn_type_q  <= '0;
            spawn_loc_q   <= '0;
            alive_mask_q  <= '0;
            alive_count_q <= '0;
            pool_full_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            spawn_id_q    <= spawn_id_d;
            spawn_type_q  <= spawn_type_d;
            spawn_loc_q   <= spawn_loc_d;
            alive_mask_q  <= alive_mask_d;
            alive_count_q <= alive_count_d;
            pool_full_q   <= pool_full_d;
        end
    end

    assign spawn_if.spawnValid    = (state_q == OFFER);
    assign spawn_if.spawnId       = 5'(spawn_id_q);
    assign spawn_if.spawnType     = spawn_type_q;
    assign spawn_if.spawnLocation = spawn_loc_q;
    assign aliveMask              = alive_mask_q;
    assign aliveCount             = alive_count_q;
    assign poolFull               = pool_full_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Directed bench for enemy_spawn_scheduler with default parameters.
module tb_enemy_spawn_scheduler;

    logic        clk       = 1'b0;
    logic        resetN    = 1'b0;
    logic        sof       = 1'b0;
    logic        enable    = 1'b0;
    logic        killed    = 1'b0;
    logic        ready     = 1'b0;
    logic [3:0]  rtype     = 4'd0;
    logic [3:0]  rloc      = 4'd0;
    logic [4:0]  killed_id = 5'd0;
    logic [15:0] alive_mask;
    logic [5:0]  alive_count;
    logic        pool_full;
    logic [15:0] exp_mask  = 16'd0;
    int          checks    = 0;
    int          errors    = 0;

    always #5 clk = ~clk;

    enemy_spawn_scheduler_if spawn_bus ();
    assign spawn_bus.spawnReady = ready;

    enemy_spawn_scheduler dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (sof),
        .enable         (enable),
        .randomType     (rtype),
        .randomLocation (rloc),
        .enemyKilled    (killed),
        .killedId       (killed_id),
        .spawn_if       (spawn_bus),
        .aliveMask      (alive_mask),
        .aliveCount     (alive_count),
        .poolFull       (pool_full)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) sof = 1'b1;
            @(negedge clk) sof = 1'b0;
        end
    endtask

    task automatic check_mask(input string tag);
        check_eq({tag, "_mask"}, 32'(alive_mask), 32'(exp_mask));
        check_eq({tag, "_count"}, 32'(alive_count), 32'($countones(exp_mask)));
    endtask

    // Full spawn with ready held high: 60 frames, then offer, then accept.
    task automatic spawn(input int exp_id, input logic [3:0] t, input logic [3:0] l);
        rtype = t;
        rloc  = l;
        ready = 1'b1;
        frames(60);
        @(negedge clk);
        check_eq("spawn_valid", 32'(spawn_bus.spawnValid), 32'd1);
        check_eq("spawn_id", 32'(spawn_bus.spawnId), 32'(exp_id));
        check_eq("spawn_type", 32'(spawn_bus.spawnType), 32'(t));
        check_eq("spawn_loc", 32'(spawn_bus.spawnLocation), 32'(l) * 32'd40);
        @(negedge clk);
        check_eq("spawn_done", 32'(spawn_bus.spawnValid), 32'd0);
        exp_mask = exp_mask | (16'd1 << exp_id);
        check_mask("spawn");
        $display("spawn id=%0d type=%0d loc=%0d mask=0x%04h count=%0d",
                 exp_id, t, 32'(l) * 32'd40, alive_mask, alive_count);
    endtask

    task automatic kill(input int id);
        @(negedge clk);
        killed    = 1'b1;
        killed_id = 5'(id);
        @(negedge clk);
        killed = 1'b0;
        if (id < 16) exp_mask = exp_mask & ~(16'd1 << id);
        check_mask("kill");
        $display("kill id=%0d mask=0x%04h count=%0d", id, alive_mask, alive_count);
    endtask

    initial begin
        // Reset values.
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(spawn_bus.spawnValid), 32'd0);
        check_eq("rst_id", 32'(spawn_bus.spawnId), 32'd0);
        check_eq("rst_type", 32'(spawn_bus.spawnType), 32'd0);
        check_eq("rst_loc", 32'(spawn_bus.spawnLocation), 32'd0);
        check_eq("rst_mask", 32'(alive_mask), 32'd0);
        check_eq("rst_count", 32'(alive_count), 32'd0);
        check_eq("rst_full", 32'(pool_full), 32'd0);
        resetN = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;

        // First spawn: nothing after 59 frames, request right after the 60th.
        rtype = 4'd5;
        rloc  = 4'd1;
        frames(59);
        repeat (3) @(negedge clk);
        check_eq("early_valid", 32'(spawn_bus.spawnValid), 32'd0);
        frames(1);
        @(negedge clk);
        check_eq("first_valid", 32'(spawn_bus.spawnValid), 32'd1);
        check_eq("first_id", 32'(spawn_bus.spawnId), 32'd0);
        check_eq("first_type", 32'(spawn_bus.spawnType), 32'd5);
        check_eq("first_loc", 32'(spawn_bus.spawnLocation), 32'd40);
        @(negedge clk);
        check_eq("first_done", 32'(spawn_bus.spawnValid), 32'd0);
        exp_mask = 16'h0001;
        check_mask("first");
        $display("spawn id=0 type=5 loc=40 mask=0x%04h", alive_mask);

        // Backpressure: outputs hold for 5 cycles, accept on the 6th.
        ready = 1'b0;
        rtype = 4'd3;
        rloc  = 4'd15;
        frames(60);
        @(negedge clk);
        check_eq("bp_valid", 32'(spawn_bus.spawnValid), 32'd1);
        check_eq("bp_id", 32'(spawn_bus.spawnId), 32'd1);
        check_eq("bp_type", 32'(spawn_bus.spawnType), 32'd3);
        check_eq("bp_loc", 32'(spawn_bus.spawnLocation), 32'd600);
        rtype = 4'd9;
        rloc  = 4'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(spawn_bus.spawnValid), 32'd1);
            check_eq("hold_id", 32'(spawn_bus.spawnId), 32'd1);
            check_eq("hold_type", 32'(spawn_bus.spawnType), 32'd3);
            check_eq("hold_loc", 32'(spawn_bus.spawnLocation), 32'd600);
        end
        ready = 1'b1;
        @(negedge clk);
        check_eq("bp_done", 32'(spawn_bus.spawnValid), 32'd0);
        exp_mask = exp_mask | 16'h0002;
        check_mask("bp");
        $display("spawn id=1 type=3 loc=600 mask=0x%04h", alive_mask);

        // Fill to MAX_ALIVE.
        for (int i = 2; i < 8; i++) spawn(i, 4'(i), 4'(i));
        check_eq("full_flag", 32'(pool_full), 32'd1);

        // Out-of-range and already-free kills change nothing.
        kill(20);
        kill(10);

        // Held in SEARCH while full; freed slot 2 is skipped in favour of rrPtr=8.
        frames(60);
        repeat (4) @(negedge clk);
        check_eq("held_valid", 32'(spawn_bus.spawnValid), 32'd0);
        kill(2);
        check_eq("unfull_flag", 32'(pool_full), 32'd0);
        @(negedge clk);
        check_eq("rr_valid", 32'(spawn_bus.spawnValid), 32'd1);
        check_eq("rr_id", 32'(spawn_bus.spawnId), 32'd8);
        @(negedge clk);
        exp_mask = exp_mask | 16'h0100;
        check_mask("rr");
        check_eq("rr_full", 32'(pool_full), 32'd1);
        $display("spawn id=8 mask=0x%04h", alive_mask);

        // Kill of slot 5 coincident with accept of slot 9.
        kill(0);
        ready = 1'b0;
        rtype = 4'd1;
        rloc  = 4'd0;
        frames(60);
        @(negedge clk);
        check_eq("kc_id", 32'(spawn_bus.spawnId), 32'd9);
        check_eq("kc_loc", 32'(spawn_bus.spawnLocation), 32'd0);
        ready     = 1'b1;
        killed    = 1'b1;
        killed_id = 5'd5;
        @(negedge clk);
        killed = 1'b0;
        exp_mask = (exp_mask & ~16'h0020) | 16'h0200;
        check_mask("kc");
        check_eq("kc_count", 32'(alive_count), 32'd7);
        $display("kill id=5 with spawn id=9 mask=0x%04h", alive_mask);

        // Lap the pool so rrPtr reaches 15 with slot 15 still alive.
        for (int i = 0; i < 16; i++) if (exp_mask[i]) kill(i);
        for (int k = 0; k < 8; k++) spawn((10 + k) % 16, 4'(k), 4'(k));
        for (int i = 0; i < 15; i++) if (exp_mask[i]) kill(i);
        for (int k = 2; k < 9; k++) spawn(k, 4'(k), 4'(15 - k));
        for (int i = 0; i < 15; i++) if (exp_mask[i]) kill(i);
        for (int k = 9; k < 15; k++) spawn(k, 4'(k), 4'(k));
        spawn(0, 4'd12, 4'd7);
        check_eq("wrap_full", 32'(pool_full), 32'd1);

        // Asynchronous reset in the middle of an offer.
        kill(9);
        ready = 1'b0;
        frames(60);
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(spawn_bus.spawnValid), 32'd1);
        check_eq("pre_rst_id", 32'(spawn_bus.spawnId), 32'd1);
        #2 resetN = 1'b0;
        #1;
        check_eq("arst_valid", 32'(spawn_bus.spawnValid), 32'd0);
        check_eq("arst_mask", 32'(alive_mask), 32'd0);
        check_eq("arst_count", 32'(alive_count), 32'd0);
        check_eq("arst_id", 32'(spawn_bus.spawnId), 32'd0);
        check_eq("arst_full", 32'(pool_full), 32'd0);
        $display("async reset mid-offer mask=0x%04h", alive_mask);
        @(negedge clk) resetN = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_valid", 32'(spawn_bus.spawnValid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
